// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types and stream-format constants for the IMEM
//                loader: loader FSM state encoding and byte-stream layout.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   // Loader FSM states.
   typedef enum logic [2:0] {
      LD_IDLE   = 3'd0,
      LD_LEN_LO = 3'd1,
      LD_LEN_HI = 3'd2,
      LD_DATA   = 3'd3,
      LD_WRITE  = 3'd4,
      LD_CHECK  = 3'd5,
      LD_DONE   = 3'd6,
      LD_ERROR  = 3'd7
   } loader_state_t;

   // Stream format: 2 length bytes, then 4 bytes per word, LSB first.
   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : word_packer
//  Description : Assembles stream bytes into a word (byte lane 0 first) and
//                keeps the running XOR checksum of every pushed byte.
//  Ports       : clk      - clock
//                clear_i  - synchronous clear of lane, word and checksum
//                push_i   - a payload byte is transferred this cycle
//                byte_i   - payload byte
//                last_o   - current lane is the final lane of the word
//                word_o   - packed word including the byte at byte_i
//                csum_o   - XOR of all bytes pushed since the last clear
//  Revision    : 1.0 - initial release
// ============================================================================
module word_packer
   import riscv_pkg::*;
(
   input  logic                        clk,
   input  logic                        clear_i,
   input  logic                        push_i,
   input  logic [7:0]                  byte_i,
   output logic                        last_o,
   output logic [8*BYTES_PER_WORD-1:0] word_o,
   output logic [7:0]                  csum_o
);

   localparam int c_LANE_W = $clog2(BYTES_PER_WORD);

   logic [c_LANE_W-1:0]         lane_q;
   logic [8*BYTES_PER_WORD-1:0] word_q;
   logic [7:0]                  csum_q;

   // Word as it will look once the current byte lands in its lane; the
   // loader captures this directly on the final byte of a word.
   always_comb begin
      word_o = word_q;
      word_o[8*lane_q +: 8] = byte_i;
   end

   assign last_o = (lane_q == c_LANE_W'(BYTES_PER_WORD - 1));
   assign csum_o = csum_q;

   // Every lane is overwritten before the word is used, so word_q needs no
   // per-word clear; the lane counter wraps naturally after the last lane.
   always_ff @(posedge clk) begin
      if (clear_i) begin
         lane_q <= '0;
         word_q <= '0;
         csum_q <= '0;
      end else if (push_i) begin
         lane_q <= lane_q + c_LANE_W'(1);
         word_q <= word_o;
         csum_q <= csum_q ^ byte_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Receives a length-prefixed, checksummed byte stream and
//                writes it word by word into instruction memory while
//                holding the core in reset until a good load completes.
//  Ports       : clk, reset          - clock, sync active-high reset
//                start               - pulse to begin a load session
//                byte_valid/byte_data/byte_ready - byte stream handshake
//                imem_we/imem_addr/imem_wdata    - IMEM write port
//                core_hold           - keep core in reset
//                done / error        - load accepted / rejected
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
   import riscv_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  core_hold,
   output logic                  done,
   output logic                  error
);

   // Largest legal word count; 17 bits so 2**16 is representable.
   localparam logic [16:0]         c_CAP = 17'(1) << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] c_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   loader_state_t         state_q;
   logic [ADDR_WIDTH:0]   widx_q;      // one extra bit: counts up to 2**ADDR_WIDTH
   logic [15:0]           len_q;
   logic                  byte_ready_q, imem_we_q, core_hold_q, done_q, error_q;
   logic [ADDR_WIDTH-1:0] imem_addr_q;
   logic [DATA_WIDTH-1:0] imem_wdata_q;

   logic                  w_xfer, w_start_ok, w_len_bad, w_last_word;
   logic                  w_pack_last;
   logic [15:0]           w_len;
   logic [ADDR_WIDTH:0]   w_widx_inc;
   logic [31:0]           w_word;
   logic [7:0]            w_csum;

   assign w_xfer      = byte_valid && byte_ready_q;
   assign w_start_ok  = start && ((state_q == LD_IDLE) || (state_q == LD_DONE) ||
                                  (state_q == LD_ERROR));
   assign w_len       = {byte_data, len_q[7:0]};
   assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > c_CAP);
   assign w_widx_inc  = widx_q + c_ONE;
   assign w_last_word = (17'(w_widx_inc) == {1'b0, len_q});

   word_packer u_packer (
      .clk     (clk),
      .clear_i (reset || w_start_ok),
      .push_i  (w_xfer && (state_q == LD_DATA)),
      .byte_i  (byte_data),
      .last_o  (w_pack_last),
      .word_o  (w_word),
      .csum_o  (w_csum)
   );

   // Outputs are registered and set on the transition into each state so
   // they are valid for the whole cycle the FSM spends there.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= LD_IDLE;
         widx_q       <= '0;
         len_q        <= '0;
         byte_ready_q <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         core_hold_q  <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         imem_we_q <= 1'b0;
         case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
               if (w_start_ok) begin
                  state_q      <= LD_LEN_LO;
                  widx_q       <= '0;
                  byte_ready_q <= 1'b1;
                  core_hold_q  <= 1'b1;
                  done_q       <= 1'b0;
                  error_q      <= 1'b0;
               end
            end
            LD_LEN_LO: begin
               if (w_xfer) begin
                  len_q[7:0] <= byte_data;
                  state_q    <= LD_LEN_HI;
               end
            end
            LD_LEN_HI: begin
               if (w_xfer) begin
                  len_q[15:8] <= byte_data;
                  if (w_len_bad) begin
                     state_q      <= LD_ERROR;
                     byte_ready_q <= 1'b0;
                     error_q      <= 1'b1;
                  end else begin
                     state_q <= LD_DATA;
                  end
               end
            end
            LD_DATA: begin
               if (w_xfer && w_pack_last) begin
                  state_q      <= LD_WRITE;
                  byte_ready_q <= 1'b0;
                  imem_we_q    <= 1'b1;
                  imem_addr_q  <= widx_q[ADDR_WIDTH-1:0];
                  imem_wdata_q <= w_word;
               end
            end
            LD_WRITE: begin
               widx_q       <= w_widx_inc;
               byte_ready_q <= 1'b1;
               state_q      <= w_last_word ? LD_CHECK : LD_DATA;
            end
            LD_CHECK: begin
               if (w_xfer) begin
                  byte_ready_q <= 1'b0;
                  if (byte_data == w_csum) begin
                     state_q     <= LD_DONE;
                     done_q      <= 1'b1;
                     core_hold_q <= 1'b0;
                  end else begin
                     state_q <= LD_ERROR;
                     error_q <= 1'b1;
                  end
               end
            end
            default: state_q <= LD_IDLE;
         endcase
      end
   end

   assign byte_ready = byte_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_hold  = core_hold_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. A monitor records IMEM
//                writes; expected contents come from the word list that was
//                streamed, and the checksum from the XOR of its bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset, start, byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready, imem_we, core_hold, done, error;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;

   int          checks = 0;
   int          errors = 0;

   logic [31:0] words_in [256];
   logic [31:0] mem      [256];
   logic [31:0] snap     [256];
   bit          written  [256];
   int          wr_count;
   int          last_addr;
   bit          gaps_en;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_hold  (core_hold),
      .done       (done),
      .error      (error)
   );

   // IMEM model: captures every write strobe away from the active edge.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         mem[imem_addr]     = imem_wdata;
         written[imem_addr] = 1'b1;
         wr_count++;
         last_addr = int'(imem_addr);
      end
   end

   function automatic logic [7:0] calc_csum(input int n);
      logic [7:0] c = 8'h00;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 4; b++) c ^= words_in[i][8*b +: 8];
      return c;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         mem[i] = 32'h0; written[i] = 1'b0;
      end
      wr_count = 0; last_addr = -1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(1); start = 1'b0;
   endtask

   // Presents one byte and returns #1 after the edge on which it transferred.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      if (gaps_en) tick($urandom_range(0, 3));
      byte_valid = 1'b1; byte_data = b;
      while (byte_ready !== 1'b1 && n < 50) begin tick(1); n++; end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL handshake_timeout: byte_ready=%b required 1", byte_ready);
      end
      tick(1);
      byte_valid = 1'b0; byte_data = $urandom();
   endtask

   task automatic send_word(input int i);
      for (int b = 0; b < 4; b++) send_byte(words_in[i][8*b +: 8]);
   endtask

   task automatic run_load(input int n, input bit bad_csum, input bit gaps);
      logic [7:0] cs = calc_csum(n);
      logic [15:0] len = 16'(n);
      if (bad_csum) cs ^= 8'h5A;
      gaps_en = gaps;
      pulse_start();
      send_byte(len[7:0]); send_byte(len[15:8]);
      for (int i = 0; i < n; i++) send_word(i);
      send_byte(cs);
      gaps_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(2); reset = 1'b0;
   endtask

   task automatic test_reset();
      start = 1'b1; reset = 1'b1; tick(1);   // reset wins over start
      start = 1'b0; tick(1); reset = 1'b0;
      checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL reset_core_hold: got %b exp 1", core_hold); end
      checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_flags: done=%b error=%b exp 0 0", done, error); end
      checks++; if (byte_ready !== 1'b0 || imem_we !== 1'b0) begin errors++; $display("FAIL reset_ready_we: ready=%b we=%b exp 0 0", byte_ready, imem_we); end
      checks++; if (imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_data: addr=%h data=%h exp 0 0", imem_addr, imem_wdata); end
   endtask

   task automatic test_directed();
      clear_mem();
      words_in[0] = 32'h00500113; words_in[1] = 32'h00C00193;
      run_load(2, 1'b0, 1'b0);
      checks++; if (done !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL dir_done: done=%b hold=%b err=%b exp 1 0 0", done, core_hold, error); end
      checks++; if (wr_count !== 2) begin errors++; $display("FAIL dir_wr_count: got %0d exp 2", wr_count); end
      checks++; if (mem[0] !== 32'h00500113 || mem[1] !== 32'h00C00193) begin errors++; $display("FAIL dir_mem: got %h %h exp 00500113 00c00193", mem[0], mem[1]); end
      tick(3);
      checks++; if (done !== 1'b1 || byte_ready !== 1'b0) begin errors++; $display("FAIL dir_done_hold: done=%b ready=%b exp 1 0", done, byte_ready); end
   endtask

   task automatic test_bad_checksum();
      clear_mem();
      run_load(2, 1'b1, 1'b0);
      checks++; if (error !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin errors++; $display("FAIL badcs_flags: err=%b done=%b hold=%b exp 1 0 1", error, done, core_hold); end
      checks++; if (wr_count !== 2 || mem[0] !== 32'h00500113 || mem[1] !== 32'h00C00193) begin errors++; $display("FAIL badcs_mem: count=%0d got %h %h", wr_count, mem[0], mem[1]); end
   endtask

   task automatic test_bad_len(input logic [15:0] len, input string name);
      clear_mem();
      pulse_start();
      checks++; if (error !== 1'b0 || byte_ready !== 1'b1) begin errors++; $display("FAIL %s_start: err=%b ready=%b exp 0 1", name, error, byte_ready); end
      send_byte(len[7:0]); send_byte(len[15:8]);
      checks++; if (error !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1 || byte_ready !== 1'b0) begin errors++; $display("FAIL %s_error: err=%b done=%b hold=%b ready=%b exp 1 0 1 0", name, error, done, core_hold, byte_ready); end
      tick(4);
      checks++; if (wr_count !== 0) begin errors++; $display("FAIL %s_no_write: got %0d exp 0", name, wr_count); end
   endtask

   task automatic test_full_load();
      int bad = 0;
      clear_mem();
      for (int i = 0; i < 256; i++) words_in[i] = $urandom();
      run_load(256, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) if (mem[i] !== words_in[i]) bad++;
      checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL full_done: done=%b err=%b exp 1 0", done, error); end
      checks++; if (wr_count !== 256 || last_addr !== 255) begin errors++; $display("FAIL full_count: count=%0d last=%0d exp 256 255", wr_count, last_addr); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL full_mem: %0d mismatching words exp 0", bad); end
   endtask

   task automatic test_random_gaps();
      int n = $urandom_range(3, 24);
      int bad = 0;
      for (int i = 0; i < n; i++) words_in[i] = $urandom();
      clear_mem();
      run_load(n, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) snap[i] = mem[i];
      clear_mem();
      run_load(n, 1'b0, 1'b1);
      for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) bad++;
      for (int i = 0; i < n; i++) if (mem[i] !== words_in[i]) bad++;
      checks++; if (bad !== 0 || wr_count !== n) begin errors++; $display("FAIL gaps_mem: %0d bad words, count=%0d exp 0 %0d", bad, wr_count, n); end
      checks++; if (done !== 1'b1 || core_hold !== 1'b0) begin errors++; $display("FAIL gaps_done: done=%b hold=%b exp 1 0", done, core_hold); end
   endtask

   task automatic test_reset_mid_load();
      clear_mem();
      for (int i = 0; i < 3; i++) words_in[i] = $urandom();
      pulse_start();
      send_byte(8'h03); send_byte(8'h00);
      send_word(0);
      send_byte(words_in[1][7:0]); send_byte(words_in[1][15:8]);
      reset = 1'b1; tick(1); reset = 1'b0;
      checks++; if (core_hold !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL midrst_state: hold=%b ready=%b done=%b err=%b exp 1 0 0 0", core_hold, byte_ready, done, error); end
      byte_valid = 1'b1; tick(6); byte_valid = 1'b0;
      checks++; if (wr_count !== 1 || written[1] !== 1'b0 || mem[0] !== words_in[0]) begin errors++; $display("FAIL midrst_mem: count=%0d w1=%b mem0=%h exp 1 0 %h", wr_count, written[1], mem[0], words_in[0]); end
   endtask

   task automatic test_start_in_data();
      clear_mem();
      words_in[0] = $urandom(); words_in[1] = $urandom();
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(words_in[0][7:0]); send_byte(words_in[0][15:8]);
      pulse_start();
      send_byte(words_in[0][23:16]); send_byte(words_in[0][31:24]);
      send_word(1);
      send_byte(calc_csum(2));
      checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL start_ign_done: done=%b err=%b exp 1 0", done, error); end
      checks++; if (wr_count !== 2 || mem[0] !== words_in[0] || mem[1] !== words_in[1]) begin errors++; $display("FAIL start_ign_mem: count=%0d got %h %h exp %h %h", wr_count, mem[0], mem[1], words_in[0], words_in[1]); end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      gaps_en = 1'b0;
      clear_mem();
      tick(1);
      test_reset();
      test_directed();
      test_bad_checksum();
      test_bad_len(16'h0000, "len_zero");
      test_bad_len(16'h0101, "len_big");
      test_full_load();
      test_random_gaps();
      test_reset_mid_load();
      test_start_in_data();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
